sseg_scan_display: RTL and testbench
====================================

// Module: sseg_scan_display
// PURPOSE
//  Downstream display stage of the ALU: takes the 16-bit binary result (int_bcd) and shows it in decimal
//  on a 4-digit multiplexed seven-segment display. A sequential shift-add-3 converter produces the BCD digits.
//  A refresh prescaler then scans one digit at a time. Replaces the single-digit combinational BCDtoSSeg path.
// PARAMETERS
//  NUM_W        16      width of binary input num (4..16)
//  REFRESH_DIV  50000   clk cycles each digit stays lit (>=2; 1 kHz digit rate at 50 MHz)
// PORTS
//  clk    in   1      single clock; all state on rising edge
//  rst    in   1      synchronous, active-high reset
//  num    in   NUM_W  unsigned binary value to display
//  sseg   out  [0:6]  segments a..g (sseg[0]=a, sseg[6]=g), active-low, registered
//  an     out  4      digit anodes, active-low one-hot, an[0]=rightmost (units), registered
//  busy   out  1      high while a conversion is in progress
// BEHAVIOUR
//  Reset (rst=1 at edge): an=4'b1111, sseg=7'b1111111, busy=0, prescaler=0, digit index=0,
//   display register=0000, last_num=0, no overflow flag, FSM=IDLE. Reset mid-conversion aborts it; no partial update.
//  Converter FSM, states IDLE / SHIFT / DONE:
//   IDLE: if num!=last_num: shift reg<=num, last_num<=num, BCD accum<=0, bit cnt<=0, busy<=1, go SHIFT.
//   SHIFT: one bit per cycle. Each BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1.
//    The accumulator is 5 nibbles, enough for 65535. After NUM_W cycles go DONE.
//   DONE: commit to display register in one cycle (no tearing), then busy<=0 and go IDLE.
//    If ten-thousands nibble!=0 (value>9999), set overflow flag; otherwise clear it and load digits 3..0.
//   Latency: num change -> display register updated NUM_W+2 edges later. busy is high NUM_W+1 cycles.
//   num changes during SHIFT/DONE are ignored. IDLE re-compares afterwards, so the final value is always converted.
//  Scanner:
//   Prescaler counts 0..REFRESH_DIV-1 and wraps. At wrap, digit index increments mod 4 (0->1->2->3->0).
//   Every edge with rst=0: an<=~(4'b0001<<index), sseg<=pattern(digit[index]).
//    First edge after reset release: an=1110 with digit 0.
//   Each anode is held exactly REFRESH_DIV cycles. Exactly one anode is low at any time after reset.
//   Display register changes take effect on the next edge and do not reset the scan.
//  Segment patterns (a..g, active-low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//   5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 blank=1111111 dash=1111110
//  Overflow flag set: all four digits show dash.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: leading zero digits (3..1, stopping at the first nonzero) show blank.
//   Digit 0 is always shown. Dashes are never blanked.
//  Not defined: all four digits are always shown, including leading zeros.
// TESTING (bench uses REFRESH_DIV=4, NUM_W=16)
//  1 Reset: rst=1 for 3 cycles -> an=1111, sseg=1111111, busy=0. Release with num=0 -> next edge an=1110, sseg=0000001.
//  2 Conversion: num=1234 -> busy high 17 cycles, then scan shows
//    an=1110 sseg=1001100; an=1101 0000110; an=1011 0010010; an=0111 1001111.
//  3 Scan timing: each anode low exactly 4 cycles, sequence 1110->1101->1011->0111->1110.
//    Num change mid-scan does not restart the sequence.
//  4 Range boundary: num=9999 -> all digits 0000100. num=10000 -> all digits 1111110.
//    num=65535 -> dashes. Back to 0 -> 0000001 on digit 0.
//  5 Change mid-conversion: num=12, then num=34 on 5th busy cycle -> display register takes 12, then 34.
//    busy deasserts only between the two conversions; no other value appears.
//  6 Reset mid-conversion: rst pulse during SHIFT -> busy=0, outputs blank, display=0.
//    With num held at 77, reconversion gives 0077.
//  7 Macro: num=7 with LEADING_ZERO_BLANK_EN -> digits 3..1 show 1111111, digit 0 shows 0001111.
//    Without the macro, digits 3..1 show 0000001.

Source files
------------

// File: rtl/sseg_scan_display.sv
// ---------------------------------------------------------------------------
// sseg_scan_display
//   Shows an unsigned binary value in decimal on a 4-digit multiplexed
//   seven-segment display. A sequential shift-add-3 converter turns num into
//   BCD whenever it changes. The result is committed to a display register
//   in a single cycle. A refresh prescaler then scans one digit at a time.
//   Values above 9999 show four dashes.
//
// Parameters
//   NUM_W        width of num (4..16)
//   REFRESH_DIV  clk cycles each digit stays lit (>= 2)
//
// Ports
//   clk   in   1      single clock, rising edge
//   rst   in   1      synchronous active-high reset
//   num   in   NUM_W  unsigned binary value to display
//   sseg  out  [0:6]  segments a..g (sseg[0]=a), active-low, registered
//   an    out  4      digit anodes, active-low one-hot, an[0]=units, registered
//   busy  out  1      high while a conversion is in progress
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits 3..1 are blanked.
//                           Digit 0 is always shown and dashes are never blanked.
// ---------------------------------------------------------------------------
module sseg_scan_display #(
    parameter int NUM_W       = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] num,
    output logic [0:6]       sseg,
    output logic [3:0]       an,
    output logic             busy
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int CNT_W = $clog2(NUM_W + 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic               load, shift_en, commit;
    logic [NUM_W-1:0]   shift_reg;
    logic [NUM_W-1:0]   last_num;
    logic [19:0]        bcd;       // 5 nibbles, enough for 65535
    logic [19:0]        bcd_adj;
    logic [CNT_W-1:0]   bit_cnt;
    logic [15:0]        disp;      // committed digits 3..0
    logic               ovf;
    logic [PRE_W-1:0]   presc;
    logic [1:0]         idx;
    logic [0:6]         digit_seg [4];
    logic [3:0]         lead_zero;

    function automatic logic [0:6] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    // ---------------- converter FSM ----------------
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and only takes effect on a rising edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (num != last_num) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == CNT_W'(NUM_W - 1)) state_nxt = DONE;
            end
            DONE: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add 3 to every nibble that is 5 or more, ahead of the left shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // values from before the edge, regardless of statement order.
    // NOTE: the display register is a plain register, not a memory array, and
    // must come out of reset as 0000 so the display is defined after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            last_num  <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            disp      <= '0;
            ovf       <= 1'b0;
        end else begin
            if (load) begin
                shift_reg <= num;
                last_num  <= num;
                bcd       <= '0;
                bit_cnt   <= '0;
                busy      <= 1'b1;
            end
            if (shift_en) begin
                {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
                bit_cnt          <= bit_cnt + 1'b1;
            end
            if (commit) begin
                busy <= 1'b0;
                // The ten-thousands nibble decides overflow; digits are left
                // untouched while overflowed since dashes hide them anyway.
                if (bcd[19:16] != 4'd0) begin
                    ovf <= 1'b1;
                end else begin
                    ovf  <= 1'b0;
                    disp <= bcd[15:0];
                end
            end
        end
    end

    // ---------------- digit decode ----------------
    // A digit counts as a leading zero only if it and every digit above it is 0.
    always_comb begin
        lead_zero    = 4'b0000;
        lead_zero[3] = (disp[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp[7:4] == 4'd0);
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (ovf)                            digit_seg[i] = SEG_DASH;
            else if (LZ_BLANK && lead_zero[i])  digit_seg[i] = SEG_BLANK;
            else                                digit_seg[i] = seg_pattern(disp[4*i +: 4]);
        end
    end

    // ---------------- scanner ----------------
    // The anode and segment registers follow the current index every cycle,
    // so a new display value shows up one edge later without restarting the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= 2'd0;
            an    <= 4'b1111;
            sseg  <= SEG_BLANK;
        end else begin
            if (presc == PRE_W'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            an   <= ~(4'b0001 << idx);
            sseg <= digit_seg[idx];
        end
    end

endmodule

// File: tb/tb_sseg_scan_display.sv
module tb_sseg_scan_display;

    localparam int NUM_W    = 16;
    localparam int RD       = 4;
    localparam int CONV_CYC = NUM_W + 1;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NUM_W-1:0] num = '0;
    logic [0:6]       sseg;
    logic [3:0]       an;
    logic             busy;

    sseg_scan_display #(.NUM_W(NUM_W), .REFRESH_DIV(RD)) dut (
        .clk  (clk),
        .rst  (rst),
        .num  (num),
        .sseg (sseg),
        .an   (an),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];        // values the display is expected to take, in order
    int model_last = 0;  // last value the converter will have accepted

    // rst as the DUT sampled it at the most recent edge
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what digit k of value v should look like, from decimal arithmetic.
    function automatic logic [0:6] exp_seg(input int v, input int k);
        int p = 1;
        int d;
        for (int i = 0; i < k; i++) p *= 10;
        if (v > 9999) return 7'b1111110;
        if (LZB && k > 0 && v < p) return 7'b1111111;
        d = (v / p) % 10;
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    function automatic int an_index(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) return i;
        return 0;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        int         cur_val   = 0;
        logic       busy_prev = 1'b0;
        int         busy_run  = 0;
        logic [3:0] an_prev   = 4'hf;
        int         an_run    = 0;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                check("rst_an", 32'(an), 32'hf);
                check("rst_sseg", 32'(sseg), 32'h7f);
                check("rst_busy", 32'(busy), 32'h0);
                exp_q.delete();
                cur_val   = 0;
                busy_prev = 1'b0;
                busy_run  = 0;
                an_prev   = 4'hf;
                an_run    = 0;
            end else begin
                check("an_onehot", 32'($countones(~an)), 32'd1);
                check("sseg_digit", 32'(sseg), 32'(exp_seg(cur_val, an_index(an))));
                if (an !== an_prev) begin
                    if (an_prev == 4'hf) begin
                        check("an_first", 32'(an), 32'(4'b1110));
                    end else begin
                        check("an_hold", 32'(an_run), 32'(RD));
                        check("an_order", 32'(an), 32'({an_prev[2:0], an_prev[3]}));
                    end
                    an_prev = an;
                    an_run  = 1;
                end else begin
                    an_run++;
                end
                if (busy === 1'b1) begin
                    busy_run++;
                end else if (busy_prev) begin
                    // Conversion finished: the new value is visible from the next edge.
                    check("busy_len", 32'(busy_run), 32'(CONV_CYC));
                    check("conv_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) cur_val = exp_q.pop_front();
                    busy_run = 0;
                end
                busy_prev = busy;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_num(input int v);
        num = NUM_W'(v);
        if (v != model_last) begin
            exp_q.push_back(v);
            model_last = v;
        end
    endtask

    // Wait until busy has stayed low for 3 samples in a row.
    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        repeat (2) @(posedge clk);
        while (quiet < 3 && n < 200) begin
            @(posedge clk); #2;
            n++;
            if (busy === 1'b0) quiet++;
            else quiet = 0;
        end
        check("idle_timeout", 32'(quiet >= 3), 32'd1);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        check("busy_timeout", 32'(busy), 32'd1);
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (ncyc) @(posedge clk);
        #2 rst = 1'b0;
        model_last = 0;
        @(posedge clk); #2;
        if (int'(num) != 0) begin
            exp_q.push_back(int'(num));
            model_last = int'(num);
        end
    endtask

    // Change num to b on the cyc-th busy cycle of a's conversion.
    task automatic mid_change(input int a, input int b, input int cyc);
        set_num(a);
        wait_busy();
        repeat (cyc - 1) @(posedge clk);
        #2 set_num(b);
        wait_idle();
    endtask

    function automatic int fresh(input int v);
        return (v == model_last) ? (v ^ 1) : v;
    endfunction

    function automatic int pick_val();
        int bnd[10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 65535};
        case ($urandom_range(0, 3))
            0:       return bnd[$urandom_range(0, 9)];
            1:       return int'($urandom_range(0, 65535));
            default: return int'($urandom_range(0, 9999));
        endcase
    endfunction

    initial begin
        int dir[13] = '{1234, 9999, 10000, 65535, 0, 7, 1, 10, 100, 1000, 9, 99, 999};
        int a, b;

        // Reset held 3 cycles, release with num=0.
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (24) @(posedge clk);

        // Directed values including the range boundaries.
        foreach (dir[i]) begin
            @(posedge clk); #2;
            set_num(dir[i]);
            wait_idle();
            repeat (18) @(posedge clk);
        end

        // Change on the 5th busy cycle: 12 then 34.
        @(posedge clk); #2;
        mid_change(12, 34, 5);
        repeat (18) @(posedge clk);

        // Change and revert during one conversion: only one conversion.
        @(posedge clk); #2;
        set_num(4321);
        wait_busy();
        repeat (3) @(posedge clk);
        #2 num = NUM_W'(555);
        repeat (3) @(posedge clk);
        #2 num = NUM_W'(4321);
        wait_idle();
        repeat (18) @(posedge clk);

        // Reset during SHIFT with num held at 77.
        @(posedge clk); #2;
        set_num(77);
        wait_busy();
        repeat (3) @(posedge clk);
        do_reset(2);
        wait_idle();
        repeat (18) @(posedge clk);

        // Randomized mix.
        for (int it = 0; it < 30; it++) begin
            @(posedge clk); #2;
            case ($urandom_range(0, 3))
                0: begin
                    set_num(pick_val());
                    wait_idle();
                end
                1: begin
                    a = fresh(pick_val());
                    b = pick_val();
                    mid_change(a, b, int'($urandom_range(1, CONV_CYC)));
                end
                2: begin
                    set_num(fresh(pick_val()));
                    wait_busy();
                    repeat ($urandom_range(0, 15)) @(posedge clk);
                    do_reset(int'($urandom_range(1, 3)));
                    wait_idle();
                end
                default: begin
                    set_num(model_last);
                end
            endcase
            repeat ($urandom_range(1, 24)) @(posedge clk);
        end

        repeat (10) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
